// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the framebuffer SRAM between APB writes and raster prefetch
// into a show-ahead pixel FIFO feeding the VGA timing generator.
module vga_fb_arbiter #(
  parameter int AW     = 20,
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 4,
  parameter int NPIX   = 307200
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb,
  output logic          wr_ack,
  input  logic          frame_start,
  input  logic          pix_pop,
  output logic [23:0]   pix_data,
  output logic          pix_empty,
  output logic          underflow,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [31:0]   mem_rdata
);
  localparam int PW = $clog2(NPIX + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {S_DONE, S_FETCH} state_t;
  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_wp, r_rp;
  logic [23:0]   r_fifo [DEPTH];
  logic          r_pend, r_uf;
  logic [CW:0]   w_occ;
  logic          w_elig, w_rd_pri, w_rd, w_wr, w_push, w_pop;
  logic          w_unused_hi;
  always_comb begin
    w_occ       = {1'b0, r_count} + (CW+1)'(r_pend);
    w_elig      = !reset && !frame_start && r_state == S_FETCH && w_occ < (CW+1)'(DEPTH);
    w_rd_pri    = w_elig && w_occ < (CW+1)'(LOW_WM);
    w_wr        = !reset && wr_req && !w_rd_pri;
    w_rd        = w_elig && !w_wr;
    w_push      = r_pend && !frame_start;
    w_pop       = pix_pop && r_count != '0;
    w_ptr_nxt   = r_ptr + 1'b1;
    w_state_nxt = frame_start ? S_FETCH :
                  (w_rd && w_ptr_nxt == PW'(NPIX)) ? S_DONE : r_state;
    wr_ack      = w_wr;
    mem_en      = w_rd || w_wr;
    mem_we      = w_wr;
    mem_addr    = w_wr ? wr_addr : w_rd ? AW'(r_ptr) : '0;
    mem_wdata   = w_wr ? wr_data : '0;
    mem_wmask   = w_wr ? wr_strb : '0;
    pix_empty   = r_count == '0;
    pix_data    = pix_empty ? '0 : r_fifo[r_rp];
    underflow   = r_uf;
    w_unused_hi = ^mem_rdata[31:24];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_DONE;
      r_ptr   <= '0;
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_pend  <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_rd;
      r_uf    <= frame_start ? 1'b0 : (r_uf || (pix_pop && r_count == '0));
      if (frame_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
      end else begin
        if (w_rd) r_ptr <= w_ptr_nxt;
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && w_push) r_fifo[r_wp] <= mem_rdata[23:0];
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized bench comparing the arbiter against a queue-based
// behavioural model of the fetch/arbitration rules, with directed corner cases.
module tb_vga_fb_arbiter;
  localparam int AW = 20, DEPTH = 8, LOW_WM = 4, NPIX = 1000;
  logic          clock = 0, reset = 1, wr_req = 0, frame_start = 0, pix_pop = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [3:0]    wr_strb = '0;
  logic          wr_ack, pix_empty, underflow, mem_en, mem_we;
  logic [23:0]   pix_data;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = '0;
  logic [3:0]    mem_wmask;
  int n_chk = 0, n_fail = 0, n_ack = 0, n_pop = 0;
  bit m_fetch = 0, m_pend = 0, m_uf = 0, g_rd = 0, g_wr = 0;
  int m_ptr = 0, m_paddr = 0, g_raddr = 0;
  logic [23:0] q[$];
  bit n_rd = 0;
  logic [AW-1:0] n_addr = '0;
  always #5 clock = ~clock;
  vga_fb_arbiter #(.AW(AW), .DEPTH(DEPTH), .LOW_WM(LOW_WM), .NPIX(NPIX)) dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_ack(wr_ack), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_empty(pix_empty), .underflow(underflow), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] pix_of(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  always @(negedge clock) begin
    n_rd   <= mem_en && !mem_we;
    n_addr <= mem_addr;
  end
  always @(posedge clock) mem_rdata <= n_rd ? pix_of(int'(n_addr)) : $urandom;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic cyc();
    int occ;
    bit elig, s_pop, s_fs, s_rst;
    logic [31:0] w;
    @(negedge clock);
    occ  = q.size() + int'(m_pend);
    elig = !reset && !frame_start && m_fetch && occ < DEPTH;
    g_rd = 0;
    g_wr = 0;
    if (elig && occ < LOW_WM) g_rd = 1;
    else if (wr_req && !reset) g_wr = 1;
    else if (elig) g_rd = 1;
    g_raddr = m_ptr;
    check("mem_en", mem_en, g_rd | g_wr);
    check("mem_we", mem_we, g_wr);
    check("wr_ack", wr_ack, g_wr);
    if (g_rd) check("rd_addr", mem_addr, m_ptr);
    if (g_wr) begin
      check("wr_addr", mem_addr, wr_addr);
      check("wr_data", mem_wdata, wr_data);
      check("wr_mask", mem_wmask, wr_strb);
    end else check("mask_idle", mem_wmask, 0);
    if (reset) check("reset_addr", mem_addr, 0);
    check("pix_empty", pix_empty, q.size() == 0);
    if (q.size() == 0) check("pix_data", pix_data, 0);
    else check("pix_data", pix_data, q[0]);
    check("underflow", underflow, m_uf);
    if (wr_ack) n_ack++;
    s_pop = pix_pop;
    s_fs  = frame_start;
    s_rst = reset;
    if (s_pop && !pix_empty && !s_fs && !s_rst) n_pop++;
    @(posedge clock);
    if (s_rst) begin
      m_fetch = 0; m_ptr = 0; m_pend = 0; m_uf = 0; q.delete();
    end else if (s_fs) begin
      m_fetch = 1; m_ptr = 0; m_pend = 0; m_uf = 0; q.delete();
    end else begin
      if (s_pop) begin
        if (q.size() != 0) void'(q.pop_front());
        else m_uf = 1;
      end
      if (m_pend) begin
        w = pix_of(m_paddr);
        q.push_back(w[23:0]);
      end
      m_pend  = g_rd;
      m_paddr = m_ptr;
      if (g_rd) begin
        m_ptr++;
        if (m_ptr == NPIX) m_fetch = 0;
      end
    end
    #1;
    if (g_wr) wr_req = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] p0;
    bit found;
    int i;
    @(posedge clock);
    #1;
    cyc();
    cyc();
    reset = 0;
    frame_start = 1;
    cyc();
    frame_start = 0;
    repeat (12) cyc();
    check("full_no_read", mem_en, 0);
    n_ack = 0;
    wr_req = 1; wr_addr = 20'h12345; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    cyc();
    check("full_wr_ack", n_ack, 1);
    frame_start = 1;
    cyc();
    frame_start = 0;
    wr_req = 1; wr_addr = AW'($urandom); wr_data = $urandom; wr_strb = 4'($urandom);
    n_ack = 0;
    repeat (40) begin
      pix_pop = !pix_empty;
      cyc();
    end
    check("starve_no_ack", n_ack, 0);
    pix_pop = 0;
    for (i = 0; i < 10 && n_ack == 0; i++) cyc();
    check("wr_after_fill", n_ack, 1);
    frame_start = 1;
    cyc();
    frame_start = 0;
    n_pop = 0;
    for (i = 0; i < 20000 && (m_fetch || m_pend || q.size() != 0); i++) begin
      pix_pop = ($urandom % 8) != 0;
      if (!wr_req && ($urandom % 6) == 0) begin
        wr_req = 1; wr_addr = AW'($urandom); wr_data = $urandom; wr_strb = 4'($urandom);
      end
      cyc();
    end
    check("frame_drained", pix_empty, 1);
    check("frame_pixels", n_pop, NPIX);
    pix_pop = 0;
    for (i = 0; i < 10 && wr_req; i++) cyc();
    repeat (4) cyc();
    check("done_idle", mem_en, 0);
    pix_pop = 1;
    cyc();
    pix_pop = 0;
    repeat (3) cyc();
    check("uf_sticky", underflow, 1);
    frame_start = 1;
    cyc();
    frame_start = 0;
    check("uf_clear", underflow, 0);
    found = 0;
    for (i = 0; i < 600 && !found; i++) begin
      pix_pop = !pix_empty;
      cyc();
      found = g_rd && g_raddr == 100;
    end
    check("saw_rd100", found, 1);
    pix_pop = 0;
    frame_start = 1;
    cyc();
    frame_start = 0;
    repeat (4) cyc();
    p0 = pix_of(0);
    check("abort_first_pix", pix_data, p0[23:0]);
    repeat (3) cyc();
    reset = 1;
    cyc();
    reset = 0;
    check("rst_empty", pix_empty, 1);
    check("rst_idle", mem_en, 0);
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
